// File: rtl/fifo_watermark.sv
// Synchronous FIFO with arbitrary depth, occupancy count, watermark flags and sticky errors.
// Define FIFO_WATERMARK_FWFT_EN for first-word fall-through reads; default is 1-cycle registered read.
module fifo_watermark #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         synch_rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
  input  logic [DATA_WIDTH-1:0]        data_input,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push_ok, pop_ok;

  // Pop is judged first so a push at full is taken only alongside an accepted pop.
  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != CNT_FULL) | pop_ok);

  // Explicit wrap keeps non-power-of-2 depths inside 0..DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (synch_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A fresh error in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  & ~clr_err) | (push & ~push_ok);
      underflow <= (underflow & ~clr_err) | (pop  & ~pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !synch_rst) mem[wr_ptr] <= data_input;
  end

`ifdef FIFO_WATERMARK_FWFT_EN
  assign data_out = empty_out ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          data_out <= '0;
    else if (synch_rst) data_out <= '0;
    else if (pop_ok)    data_out <= mem[rd_ptr];
  end
`endif

  assign full_out     = (count == CNT_FULL);
  assign empty_out    = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);
endmodule

// File: tb/tb_fifo_watermark.sv
// Directed bench for fifo_watermark: queue model checked every cycle on a DEPTH=8 and a DEPTH=5 instance.
module tb_fifo_watermark;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic synch_rst = 1'b0;
  logic clr_err = 1'b0;
  logic push_v [2];
  logic pop_v  [2];
  logic [7:0] din_v [2];

  logic [7:0] dout_a, dout_b;
  logic [3:0] cnt_a;
  logic [2:0] cnt_b;
  logic full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic full_b, empty_b, af_b, ae_b, ovf_b, udf_b;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  fifo_watermark #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
    .clk(clk), .reset(reset), .synch_rst(synch_rst), .push(push_v[0]), .pop(pop_v[0]),
    .clr_err(clr_err), .data_input(din_v[0]), .data_out(dout_a), .count(cnt_a),
    .full_out(full_a), .empty_out(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ovf_a), .underflow(udf_a));

  fifo_watermark #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_b (
    .clk(clk), .reset(reset), .synch_rst(synch_rst), .push(push_v[1]), .pop(pop_v[1]),
    .clr_err(clr_err), .data_input(din_v[1]), .data_out(dout_b), .count(cnt_b),
    .full_out(full_b), .empty_out(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ovf_b), .underflow(udf_b));

  // Reference model: one queue per instance, rules applied to the queue length.
  int dep [2] = '{8, 5};
  int afl [2] = '{6, 4};
  int ael [2] = '{2, 1};
  logic [7:0] q [2][$];
  bit m_ovf [2];
  bit m_udf [2];
  logic [7:0] m_dout [2];

  always @(posedge clk or posedge reset) begin : model
    bit pok, wok;
    for (int k = 0; k < 2; k++) begin
      if (reset || synch_rst) begin
        q[k].delete();
        m_ovf[k] = 0;
        m_udf[k] = 0;
        m_dout[k] = 8'h00;
      end else begin
        pok = pop_v[k] && (q[k].size() != 0);
        wok = push_v[k] && ((q[k].size() < dep[k]) || pok);
        m_ovf[k] = (m_ovf[k] && !clr_err) || (push_v[k] && !wok);
        m_udf[k] = (m_udf[k] && !clr_err) || (pop_v[k] && !pok);
        if (pok) m_dout[k] = q[k].pop_front();
        if (wok) q[k].push_back(din_v[k]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input string p, input logic [31:0] cnt, input logic full,
                     input logic empty, input logic af, input logic ae, input logic ovf,
                     input logic udf, input logic [7:0] dout);
    int n;
    logic [7:0] exp_d;
    n = q[k].size();
`ifdef FIFO_WATERMARK_FWFT_EN
    exp_d = (n != 0) ? q[k][0] : 8'h00;
`else
    exp_d = m_dout[k];
`endif
    chk({p, "_count"}, cnt, n);
    chk({p, "_full"}, full, n == dep[k]);
    chk({p, "_empty"}, empty, n == 0);
    chk({p, "_afull"}, af, n >= afl[k]);
    chk({p, "_aempty"}, ae, n <= ael[k]);
    chk({p, "_ovf"}, ovf, m_ovf[k]);
    chk({p, "_udf"}, udf, m_udf[k]);
    chk({p, "_dout"}, dout, exp_d);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, "a", cnt_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a, dout_a);
      cmp(1, "b", cnt_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b, dout_b);
      chk("b_wrptr_range", u_b.wr_ptr < 3'd5, 1);
      chk("b_rdptr_range", u_b.rd_ptr < 3'd5, 1);
    end
  end

  task automatic step(input logic ap, input logic aq, input logic [7:0] ad,
                      input logic bp, input logic bq, input logic [7:0] bd);
    push_v[0] = ap; pop_v[0] = aq; din_v[0] = ad;
    push_v[1] = bp; pop_v[1] = bq; din_v[1] = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      push_v[k] = 0; pop_v[k] = 0; din_v[k] = 8'h00;
    end
    #1 reset = 1'b1;
    #7;
    chk("rst_count", cnt_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_aempty", ae_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_afull", af_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_ovf", ovf_a, 0);
    #5 reset = 1'b0;
    chk_en = 1;

    // Fill to full, then one rejected push.
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 8'(i), 0, 0, 8'h00);
      chk("t1_count", cnt_a, i);
      if (i == 5) chk("t1_af_at5", af_a, 0);
      if (i == 6) chk("t1_af_at6", af_a, 1);
    end
    chk("t1_full", full_a, 1);
    step(1, 0, 8'h09, 0, 0, 8'h00);
    chk("t1_ovf", ovf_a, 1);
    chk("t1_count_full", cnt_a, 8);

    // Drain in order, then one rejected pop.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 8'h00, 0, 0, 8'h00);
`ifndef FIFO_WATERMARK_FWFT_EN
      chk("t2_dout", dout_a, i);
`endif
      if (8 - i == 3) chk("t2_ae_at3", ae_a, 0);
      if (8 - i == 2) chk("t2_ae_at2", ae_a, 1);
    end
    chk("t2_empty", empty_a, 1);
    step(0, 1, 8'h00, 0, 0, 8'h00);
    chk("t2_udf", udf_a, 1);
    chk("t2_count0", cnt_a, 0);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("clr_ovf", ovf_a, 0);
    chk("clr_udf", udf_a, 0);

    // DEPTH=5: prime 3, 12 simultaneous push/pop cycles, drain.
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, 8'(8'h40 + i));
    for (int i = 3; i < 15; i++) step(0, 0, 8'h00, 1, 1, 8'(8'h40 + i));
    chk("t3_count", cnt_b, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1, 8'h00);
`ifndef FIFO_WATERMARK_FWFT_EN
    chk("t3_last", dout_b, 8'h4E);
`endif
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0, 8'(8'h60 + i));
    chk("t3_cap", cnt_b, 5);
    chk("t3_ovf", ovf_b, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 1, 8'h00);

    // Push+pop at full keeps count, no overflow.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h10 + i), 0, 0, 8'h00);
    step(1, 1, 8'h20, 0, 0, 8'h00);
    chk("t4_count_full", cnt_a, 8);
    chk("t4_no_ovf", ovf_a, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 0, 8'h00);
    step(1, 1, 8'h77, 0, 0, 8'h00);
    chk("t4_count1", cnt_a, 1);
    chk("t4_udf", udf_a, 1);
    step(0, 1, 8'h00, 0, 0, 8'h00);
    clr_err = 1'b1;
    step(0, 1, 8'h00, 0, 0, 8'h00);
    chk("set_wins", udf_a, 1);
    idle();
    clr_err = 1'b0;
    chk("clr_after", udf_a, 0);

    // synch_rst from count 4 with overflow set, overriding push and pop.
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h30 + i), 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0, 8'h00);
    chk("t5_count4", cnt_a, 4);
    chk("t5_ovf", ovf_a, 1);
    synch_rst = 1'b1;
    step(1, 1, 8'hEE, 0, 0, 8'h00);
    synch_rst = 1'b0;
    chk("t5_srst_count", cnt_a, 0);
    chk("t5_srst_empty", empty_a, 1);
    chk("t5_srst_ovf", ovf_a, 0);
    chk("t5_srst_dout", dout_a, 0);

    // Async reset between edges.
    step(1, 0, 8'h51, 0, 0, 8'h00);
    step(1, 1, 8'h52, 0, 0, 8'h00);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("t5_arst_count", cnt_a, 0);
    chk("t5_arst_empty", empty_a, 1);
    chk("t5_arst_dout", dout_a, 0);
    #1 reset = 1'b0;
    idle();

`ifdef FIFO_WATERMARK_FWFT_EN
    step(1, 0, 8'hA5, 0, 0, 8'h00);
    chk("t6_fwft_head", dout_a, 8'hA5);
    idle();
    chk("t6_fwft_hold", dout_a, 8'hA5);
    step(0, 1, 8'h00, 0, 0, 8'h00);
    chk("t6_fwft_zero", dout_a, 8'h00);
    chk("t6_fwft_empty", empty_a, 1);
`endif
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_watermark.md
Name: fifo_watermark

Overview:
Parametrised synchronous FIFO, the next generation of the team's counter-based FIFO. Adds:
- arbitrary (non-power-of-2) depth;
- occupancy count output;
- programmable almost-full and almost-empty watermarks;
- sticky overflow and underflow error flags;
- simultaneous push and pop accepted at full.

It sits between a producer and a consumer in the same clock domain, such as UART or processor data paths.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 8, number of storage words; any integer >= 2, power of 2 not required
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous reset, active-high
synch_rst  input  1  synchronous clear of pointers, count and error flags
push  input  1  write request
pop  input  1  read request
clr_err  input  1  synchronous clear of overflow and underflow only
data_input  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  read data
count  output  CLOG2(DEPTH+1)  current occupancy, 0..DEPTH
full_out  output  1  count == DEPTH
empty_out  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
overflow  output  1  sticky: a push was rejected
underflow  output  1  sticky: a pop was rejected

Behaviour:
- Reset (async, reset=1): rd_ptr=0, wr_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Resulting flags: empty_out=1, almost_empty=1, full_out=0, almost_full=0.
- Reset mid-operation discards all contents immediately, independent of clk.
- synch_rst=1 at a clock edge has the same effect as reset on pointers, count, overflow, underflow and data_out. It overrides push, pop and clr_err in that cycle. Memory contents are don't-care.
- Accept rules, evaluated on current registered count:
  - pop_ok = pop & (count != 0)
  - push_ok = push & ((count != DEPTH) | pop_ok)
  - Push is therefore accepted at full only when a pop is accepted in the same cycle.
  - Pop at empty is never accepted, even with a simultaneous push; there is no bypass.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither. Never exceeds DEPTH, never goes below 0.
- Pointers:
  - wr_ptr advances on push_ok; rd_ptr advances on pop_ok.
  - Each wraps from DEPTH-1 to 0 via explicit compare, not natural binary overflow.
  - Pointer width is CLOG2(DEPTH).
- Storage: word written at wr_ptr on push_ok.
- Read path, default mode: data_out is registered and updates at the edge where pop_ok=1 with mem[rd_ptr], so read latency is 1 cycle. data_out holds its value when there is no pop_ok.
- Flags are combinational decodes of registered count and so are valid in the same cycle count changes, with no extra latency.
- Error flags:
  - overflow sets on push & ~push_ok; underflow sets on pop & ~pop_ok.
  - Both hold until clr_err, synch_rst or reset.
  - If set and clear coincide (clr_err with a new error in the same cycle), set wins.
- Rejected operations never change pointers, count or memory.

Optional Feature:
Macro FIFO_WATERMARK_FWFT_EN.
- Defined: first-word fall-through mode.
  - data_out continuously presents mem[rd_ptr] whenever empty_out=0, so a word is visible on the cycle after its push lands.
  - pop acknowledges and removes the head.
  - data_out is 0 while empty.
- Not defined: registered 1-cycle read latency as described in Behaviour.
- Accept rules, count and flags are identical in both modes.

Test Plan:
1. Defaults; push 8 words 0x01..0x08, then one more push 0x09 -> count 0..8; almost_full rises at count=6; full_out=1 at 8; overflow=1; 0x09 not stored.
2. From full, pop 8 -> data_out sequence 0x01..0x08, each 1 cycle after its pop; almost_empty=1 at count=2; empty_out=1 at 0. One extra pop -> underflow=1, count stays 0.
3. DEPTH=5: 12 interleaved push/pop cycles so pointers wrap twice -> data order preserved; count never exceeds 5; pointers never reach 5.
4. Full (count=8) with push=1, pop=1 in the same cycle -> count stays 8, both accepted, overflow stays 0. Empty with push=1, pop=1 -> count becomes 1, underflow=1.
5. Count=4 with overflow=1: assert synch_rst -> count=0, empty_out=1, overflow=0. Separately, assert reset asynchronously between clock edges -> outputs reach reset values before the next edge.
6. FIFO_WATERMARK_FWFT_EN defined: push 0xA5 into empty FIFO -> data_out=0xA5 the cycle after, with no pop. Pop -> data_out=0, empty_out=1.
